// File: rtl/calc_input_controller_if.sv
// ============================================================================
// Module      : calc_input_controller_if
// Description : Keypad/ALU/screen bundle for the calculator input sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface calc_input_controller_if;
    logic        enter;
    logic [2:0]  pos_x;
    logic [1:0]  pos_y;
    logic        mode;
    logic [15:0] alu_result;
    logic        alu_done;
    logic [15:0] op1;
    logic [15:0] op2;
    logic [2:0]  op;
    logic        alu_start;
    logic [15:0] input_screen;
    logic [1:0]  state;
    logic        err;

    // Controller side
    modport master (
        input  enter, pos_x, pos_y, mode, alu_result, alu_done,
        output op1, op2, op, alu_start, input_screen, state, err
    );

    // Keypad / ALU / screen side
    modport slave (
        output enter, pos_x, pos_y, mode, alu_result, alu_done,
        input  op1, op2, op, alu_start, input_screen, state, err
    );
endinterface

`default_nettype wire

// File: rtl/calc_input_controller.sv
// ============================================================================
// Module      : calc_input_controller
// Description : Decodes keypad presses into operands/operator, runs the ALU
//               start/done handshake with timeout, and drives the entry box.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module calc_input_controller #(
    parameter int MAX_DIGITS = 4,
    parameter int TIMEOUT    = 1023,
    parameter int TO_W       = 10
) (
    input  wire logic               clk,
    input  wire logic               rst,
    calc_input_controller_if.master ctrl
);

    localparam int CNT_W = $clog2(MAX_DIGITS + 1);

    typedef enum logic [1:0] {
        S_OP1    = 2'd0,
        S_OP2    = 2'd1,
        S_WAIT   = 2'd2,
        S_RESULT = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       entry_q, entry_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [15:0]       op1_q, op1_d;
    logic [15:0]       op2_q, op2_d;
    logic [2:0]        op_q, op_d;
    logic [15:0]       result_q, result_d;
    logic              err_q, err_d;
    logic              start_q, start_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;

    logic [3:0]  key_val;
    logic        key_digit, key_oper, key_ce, key_clr, key_exe;
    logic [2:0]  oper_code;
    logic [15:0] entry_app;
    logic        room;

    assign key_val   = {ctrl.pos_y, ctrl.pos_x[1:0]};
    assign key_digit = ctrl.enter && !ctrl.pos_x[2] && (ctrl.mode || (key_val < 4'd10));
    assign key_oper  = ctrl.enter && ((ctrl.pos_x == 3'd4) ||
                                      (ctrl.pos_x == 3'd5 && ctrl.pos_y == 2'd0));
    assign oper_code = (ctrl.pos_x == 3'd4) ? {1'b0, ctrl.pos_y} : 3'd4;
    assign key_ce    = ctrl.enter && (ctrl.pos_x == 3'd5) && (ctrl.pos_y == 2'd1);
    assign key_clr   = ctrl.enter && (ctrl.pos_x == 3'd5) && (ctrl.pos_y == 2'd2);
    assign key_exe   = ctrl.enter && (ctrl.pos_x == 3'd5) && (ctrl.pos_y == 2'd3);
    assign entry_app = {entry_q[11:0], key_val};
    assign room      = (count_q < CNT_W'(MAX_DIGITS));

    always_comb begin
        state_d  = state_q;
        entry_d  = entry_q;
        count_d  = count_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        op_d     = op_q;
        result_d = result_q;
        err_d    = err_q;
        start_d  = 1'b0;
        to_cnt_d = to_cnt_q;

        // CLR beats everything, including a simultaneous alu_done in WAIT
        if (key_clr || (state_q == S_RESULT && key_ce)) begin
            state_d  = S_OP1;
            entry_d  = '0;
            count_d  = '0;
            op1_d    = '0;
            op2_d    = '0;
            op_d     = '0;
            result_d = '0;
            err_d    = 1'b0;
        end else begin
            case (state_q)
                S_OP1, S_OP2: begin
                    if (key_digit) begin
                        err_d = 1'b0;
                        if (room) begin
                            entry_d = entry_app;
                            count_d = count_q + CNT_W'(1);
                        end
                    end else if (key_ce) begin
                        entry_d = '0;
                        count_d = '0;
                    end else if (key_oper) begin
                        if (state_q == S_OP1) begin
                            op1_d   = entry_q;
                            op_d    = oper_code;
                            entry_d = '0;
                            count_d = '0;
                            state_d = S_OP2;
                        end else if (count_q == '0) begin
                            op_d = oper_code;
                        end
                    end else if (key_exe && state_q == S_OP2) begin
                        op2_d    = entry_q;
                        start_d  = 1'b1;
                        to_cnt_d = '0;
                        state_d  = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (ctrl.alu_done) begin
                        result_d = ctrl.alu_result;
                        state_d  = S_RESULT;
                    end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
                        result_d = 16'hFFFF;
                        err_d    = 1'b1;
                        state_d  = S_RESULT;
                    end else begin
                        to_cnt_d = to_cnt_q + TO_W'(1);
                    end
                end
                S_RESULT: begin
                    if (key_digit) begin
                        entry_d = {12'h000, key_val};
                        count_d = CNT_W'(1);
                        err_d   = 1'b0;
                        state_d = S_OP1;
                    end else if (key_oper) begin
                        op1_d   = result_q;
                        op_d    = oper_code;
                        entry_d = '0;
                        count_d = '0;
                        state_d = S_OP2;
                    end
                end
                default: state_d = S_OP1;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_OP1;
            entry_q  <= '0;
            count_q  <= '0;
            op1_q    <= '0;
            op2_q    <= '0;
            op_q     <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            start_q  <= 1'b0;
            to_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            entry_q  <= entry_d;
            count_q  <= count_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            op_q     <= op_d;
            result_q <= result_d;
            err_q    <= err_d;
            start_q  <= start_d;
            to_cnt_q <= to_cnt_d;
        end
    end

    // The entry box shows the operand being typed until a result exists
    assign ctrl.input_screen = (state_q == S_RESULT) ? result_q : entry_q;
    assign ctrl.op1          = op1_q;
    assign ctrl.op2          = op2_q;
    assign ctrl.op           = op_q;
    assign ctrl.alu_start    = start_q;
    assign ctrl.state        = state_q;
    assign ctrl.err          = err_q;

endmodule

`default_nettype wire

// File: tb/tb_calc_input_controller.sv
// ============================================================================
// Module      : tb_calc_input_controller
// Description : Vector table, corner sequences and random keys vs a model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_calc_input_controller;

    localparam int TIMEOUT = 1023;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    calc_input_controller_if bus ();

    calc_input_controller #(
        .MAX_DIGITS(4),
        .TIMEOUT   (TIMEOUT),
        .TO_W      (10)
    ) dut (
        .clk (clk),
        .rst (rst),
        .ctrl(bus)
    );

    typedef struct {
        logic        en;
        logic [2:0]  x;
        logic [1:0]  y;
        logic        md;
        logic        done;
        logic [15:0] res;
        logic [1:0]  st;
        logic [15:0] scr;
        logic [15:0] o1;
        logic [15:0] o2;
        logic [2:0]  op;
        logic        start;
        logic        err;
    } vec_t;

    vec_t vecs[$];

    // Behavioural model: operand being typed is a queue of digits
    int          m_state;
    int          m_dig[$];
    logic [15:0] m_op1, m_op2, m_res;
    logic [2:0]  m_op;
    logic        m_err, m_start;
    int          m_wait;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [1:0] st, input logic [15:0] scr,
                           input logic [15:0] o1, input logic [15:0] o2, input logic [2:0] op,
                           input logic start, input logic err);
        chk({tag, ".state"}, 16'(bus.state), 16'(st));
        chk({tag, ".screen"}, bus.input_screen, scr);
        chk({tag, ".op1"}, bus.op1, o1);
        chk({tag, ".op2"}, bus.op2, o2);
        chk({tag, ".op"}, 16'(bus.op), 16'(op));
        chk({tag, ".alu_start"}, 16'(bus.alu_start), 16'(start));
        chk({tag, ".err"}, 16'(bus.err), 16'(err));
    endtask

    function automatic logic [15:0] entry_val();
        int v = 0;
        foreach (m_dig[i]) v = v * 16 + m_dig[i];
        return 16'(v);
    endfunction

    task automatic model_reset();
        m_state = 0; m_dig.delete(); m_op1 = 0; m_op2 = 0; m_res = 0;
        m_op = 0; m_err = 0; m_start = 0; m_wait = 0;
    endtask

    task automatic model_step(input logic en, input logic [2:0] x, input logic [1:0] y,
                              input logic md, input logic done, input logic [15:0] res);
        string kind = "none";
        int    val  = 0;
        if (en) begin
            if (x < 4) begin
                val = int'(y) * 4 + int'(x);
                if (md || val <= 9) kind = "dig";
            end else if (x == 4) begin
                kind = "opr"; val = int'(y);
            end else if (x == 5) begin
                case (y)
                    2'd0: begin kind = "opr"; val = 4; end
                    2'd1: kind = "ce";
                    2'd2: kind = "clr";
                    default: kind = "exe";
                endcase
            end
        end
        m_start = 0;
        if (kind == "clr" || (m_state == 3 && kind == "ce")) begin
            model_reset();
        end else if (m_state == 0 || m_state == 1) begin
            if (kind == "dig") begin
                m_err = 0;
                if (m_dig.size() < 4) m_dig.push_back(val);
            end else if (kind == "ce") begin
                m_dig.delete();
            end else if (kind == "opr") begin
                if (m_state == 0) begin
                    m_op1 = entry_val(); m_op = 3'(val); m_dig.delete(); m_state = 1;
                end else if (m_dig.size() == 0) begin
                    m_op = 3'(val);
                end
            end else if (kind == "exe" && m_state == 1) begin
                m_op2 = entry_val(); m_start = 1; m_wait = 0; m_state = 2;
            end
        end else if (m_state == 2) begin
            m_wait++;
            if (done) begin
                m_res = res; m_state = 3;
            end else if (m_wait == TIMEOUT) begin
                m_res = 16'hFFFF; m_err = 1; m_state = 3;
            end
        end else begin
            if (kind == "dig") begin
                m_dig.delete(); m_dig.push_back(val); m_err = 0; m_state = 0;
            end else if (kind == "opr") begin
                m_op1 = m_res; m_op = 3'(val); m_dig.delete(); m_state = 1;
            end
        end
    endtask

    task automatic cycle(input logic en, input logic [2:0] x, input logic [1:0] y,
                         input logic md, input logic done, input logic [15:0] res);
        bus.enter = en; bus.pos_x = x; bus.pos_y = y; bus.mode = md;
        bus.alu_done = done; bus.alu_result = res;
        @(posedge clk);
        model_step(en, x, y, md, done, res);
        #1;
        chk_all("model", 2'(m_state), (m_state == 3) ? m_res : entry_val(),
                m_op1, m_op2, m_op, m_start, m_err);
    endtask

    task automatic press(input logic [2:0] x, input logic [1:0] y);
        cycle(1'b1, x, y, 1'b1, 1'b0, 16'h0);
    endtask

    task automatic idle();
        cycle(1'b0, 3'd0, 2'd0, 1'b1, 1'b0, 16'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    function automatic vec_t V(input logic en, input logic [2:0] x, input logic [1:0] y,
                               input logic md, input logic done, input logic [15:0] res,
                               input logic [1:0] st, input logic [15:0] scr, input logic [15:0] o1,
                               input logic [15:0] o2, input logic [2:0] op, input logic start,
                               input logic err);
        vec_t v;
        v.en = en; v.x = x; v.y = y; v.md = md; v.done = done; v.res = res;
        v.st = st; v.scr = scr; v.o1 = o1; v.o2 = o2; v.op = op; v.start = start; v.err = err;
        return v;
    endfunction

    int delay = 5;

    initial begin
        // key1 key2 + key3 EXE, done(0x15), SUB, MUL, 7, +, CE, CLR
        vecs.push_back(V(1, 1, 0, 1, 0, 0,       0, 16'h0001, 0,       0, 0, 0, 0));
        vecs.push_back(V(1, 2, 0, 1, 0, 0,       0, 16'h0012, 0,       0, 0, 0, 0));
        vecs.push_back(V(1, 4, 0, 1, 0, 0,       1, 16'h0000, 16'h12,  0, 0, 0, 0));
        vecs.push_back(V(1, 3, 0, 1, 0, 0,       1, 16'h0003, 16'h12,  0, 0, 0, 0));
        vecs.push_back(V(1, 5, 3, 1, 0, 0,       2, 16'h0003, 16'h12,  3, 0, 1, 0));
        vecs.push_back(V(0, 0, 0, 1, 0, 0,       2, 16'h0003, 16'h12,  3, 0, 0, 0));
        vecs.push_back(V(0, 0, 0, 1, 1, 16'h15,  3, 16'h0015, 16'h12,  3, 0, 0, 0));
        vecs.push_back(V(1, 4, 1, 1, 0, 0,       1, 16'h0000, 16'h15,  3, 1, 0, 0));
        vecs.push_back(V(1, 4, 2, 1, 0, 0,       1, 16'h0000, 16'h15,  3, 2, 0, 0));
        vecs.push_back(V(1, 3, 1, 1, 0, 0,       1, 16'h0007, 16'h15,  3, 2, 0, 0));
        vecs.push_back(V(1, 4, 0, 1, 0, 0,       1, 16'h0007, 16'h15,  3, 2, 0, 0));
        vecs.push_back(V(1, 5, 1, 1, 0, 0,       1, 16'h0000, 16'h15,  3, 2, 0, 0));
        vecs.push_back(V(1, 5, 2, 1, 0, 0,       0, 16'h0000, 0,       0, 0, 0, 0));
        // Five 7s: fifth is dropped; decimal B ignored, decimal 9 accepted
        vecs.push_back(V(1, 3, 1, 1, 0, 0,       0, 16'h0007, 0,       0, 0, 0, 0));
        vecs.push_back(V(1, 3, 1, 1, 0, 0,       0, 16'h0077, 0,       0, 0, 0, 0));
        vecs.push_back(V(1, 3, 1, 1, 0, 0,       0, 16'h0777, 0,       0, 0, 0, 0));
        vecs.push_back(V(1, 3, 1, 1, 0, 0,       0, 16'h7777, 0,       0, 0, 0, 0));
        vecs.push_back(V(1, 3, 1, 1, 0, 0,       0, 16'h7777, 0,       0, 0, 0, 0));
        vecs.push_back(V(1, 3, 2, 0, 0, 0,       0, 16'h7777, 0,       0, 0, 0, 0));
        vecs.push_back(V(1, 5, 2, 0, 0, 0,       0, 16'h0000, 0,       0, 0, 0, 0));
        vecs.push_back(V(1, 1, 2, 0, 0, 0,       0, 16'h0009, 0,       0, 0, 0, 0));
        vecs.push_back(V(1, 5, 2, 1, 0, 0,       0, 16'h0000, 0,       0, 0, 0, 0));
        // 1 + 3 EXE, then CLR together with alu_done, stray done, EXE in OP1, OR
        vecs.push_back(V(1, 1, 0, 1, 0, 0,       0, 16'h0001, 0,       0, 0, 0, 0));
        vecs.push_back(V(1, 4, 0, 1, 0, 0,       1, 16'h0000, 16'h1,   0, 0, 0, 0));
        vecs.push_back(V(1, 3, 0, 1, 0, 0,       1, 16'h0003, 16'h1,   0, 0, 0, 0));
        vecs.push_back(V(1, 5, 3, 1, 0, 0,       2, 16'h0003, 16'h1,   3, 0, 1, 0));
        vecs.push_back(V(1, 5, 2, 1, 1, 16'h1234, 0, 16'h0000, 0,      0, 0, 0, 0));
        vecs.push_back(V(0, 0, 0, 1, 1, 16'h5555, 0, 16'h0000, 0,      0, 0, 0, 0));
        vecs.push_back(V(1, 5, 3, 1, 0, 0,       0, 16'h0000, 0,       0, 0, 0, 0));
        vecs.push_back(V(1, 1, 0, 1, 0, 0,       0, 16'h0001, 0,       0, 0, 0, 0));
        vecs.push_back(V(1, 5, 0, 1, 0, 0,       1, 16'h0000, 16'h1,   0, 4, 0, 0));

        bus.enter = 0; bus.pos_x = 0; bus.pos_y = 0; bus.mode = 1;
        bus.alu_done = 0; bus.alu_result = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_all("reset", 2'd0, 16'h0, 16'h0, 16'h0, 3'd0, 1'b0, 1'b0);

        foreach (vecs[i]) begin
            bus.enter = vecs[i].en; bus.pos_x = vecs[i].x; bus.pos_y = vecs[i].y;
            bus.mode = vecs[i].md; bus.alu_done = vecs[i].done; bus.alu_result = vecs[i].res;
            @(posedge clk);
            #1;
            chk_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].scr, vecs[i].o1, vecs[i].o2,
                    vecs[i].op, vecs[i].start, vecs[i].err);
        end

        // Timeout: exactly TIMEOUT cycles in WAIT, then a digit clears err
        do_reset();
        press(1, 0); press(4, 0); press(2, 0); press(5, 3);
        repeat (TIMEOUT - 1) idle();
        chk("to.still_wait", 16'(bus.state), 16'd2);
        idle();
        chk("to.state", 16'(bus.state), 16'd3);
        chk("to.err", 16'(bus.err), 16'd1);
        chk("to.screen", bus.input_screen, 16'hFFFF);
        press(1, 1);
        chk("to.dig_err", 16'(bus.err), 16'd0);
        chk("to.dig_screen", bus.input_screen, 16'h0005);
        chk("to.dig_state", 16'(bus.state), 16'd0);

        // alu_done on the timeout cycle wins
        press(4, 0); press(2, 0); press(5, 3);
        repeat (TIMEOUT - 1) idle();
        cycle(0, 0, 0, 1, 1, 16'h0ABC);
        chk("tie.err", 16'(bus.err), 16'd0);
        chk("tie.screen", bus.input_screen, 16'h0ABC);

        // Async reset mid-entry and mid-WAIT (during the alu_start cycle)
        do_reset();
        press(1, 0); press(2, 0);
        #3 rst = 1'b1;
        #1;
        chk("arst1.screen", bus.input_screen, 16'h0);
        chk("arst1.state", 16'(bus.state), 16'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        press(1, 0); press(4, 0); press(2, 0); press(5, 3);
        #3 rst = 1'b1;
        #1;
        chk("arst2.start", 16'(bus.alu_start), 16'd0);
        chk("arst2.state", 16'(bus.state), 16'd0);
        chk("arst2.op1", bus.op1, 16'h0);
        chk("arst2.op2", bus.op2, 16'h0);
        @(posedge clk);
        #1;
        chk("arst2.start_held", 16'(bus.alu_start), 16'd0);
        rst = 1'b0;
        model_reset();

        // Random keys against the model
        for (int n = 0; n < 5000; n++) begin
            logic        en, md, done;
            logic [2:0]  x;
            logic [1:0]  y;
            int          r;
            en = 1'($urandom % 2);
            md = 1'($urandom % 2);
            r  = int'($urandom % 16);
            if (r < 8)       x = 3'($urandom % 4);
            else if (r < 12) x = 3'd4;
            else if (r < 15) x = 3'd5;
            else             x = 3'(6 + $urandom % 2);
            y = 2'($urandom % 4);
            if (m_state == 2) done = (m_wait + 1 == delay);
            else              done = ($urandom % 32 == 0);
            cycle(en, x, y, md, done, 16'($urandom));
            if (m_start) begin
                r = int'($urandom % 8);
                if (r == 0)      delay = TIMEOUT;
                else if (r == 1) delay = 2000;
                else             delay = int'($urandom_range(1, 20));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/calc_input_controller.md
Name: calc_input_controller

Overview:
- Sequencer between the 6x4 keypad grid cursor and the calculator datapath (ALU plus screen).
- On each debounced enter pulse it decodes the key under the cursor and builds op1 and op2.
- It latches the operator, starts the ALU with a start/done handshake, and drives input_screen.
- It sits between grid_cursor and calculator_screen / the ALU, all in the clk domain.

Parameters:
MAX_DIGITS, 4, digits accepted per operand (4 nibbles = 16 bits)
TIMEOUT, 1023, clk cycles to wait for alu_done before flagging an error
TO_W, 10, width of the timeout counter (must hold TIMEOUT)

Ports:
clk  in  1  system clock, single domain
rst  in  1  reset, asynchronous, active-high
enter  in  1  one-cycle key-press pulse (debounced BTNC)
pos_x  in  3  cursor column 0..5
pos_y  in  2  cursor row 0..3
mode  in  1  0 = decimal (BCD digits), 1 = hexadecimal
alu_result  in  16  ALU output, valid when alu_done=1
alu_done  in  1  one-cycle ALU completion pulse
op1  out  16  first operand, nibble-packed
op2  out  16  second operand, nibble-packed
op  out  3  operator code: 0 ADD, 1 SUB, 2 MUL, 3 AND, 4 OR
alu_start  out  1  one-cycle start pulse to the ALU
input_screen  out  16  value shown in the entry box
state  out  2  0 OP1, 1 OP2, 2 WAIT, 3 RESULT
err  out  1  sticky ALU-timeout flag, cleared by CLR or a new digit

Behaviour:
Reset: all outputs and registers are 0; state=OP1.

Key decode (only when enter=1):
- pos_x 0..3 is a digit, value {pos_y, pos_x[1:0]}, range 0..F.
- pos_x=4 is an operator: rows 0..3 map to ADD, SUB, MUL, AND.
- pos_x=5: row 0 = OR, row 1 = CE, row 2 = CLR, row 3 = EXE.
- pos_x 6..7 is no-op.
- In decimal mode, digits A..F are no-op. mode is sampled only at the enter edge.

Digit append:
- If count<MAX_DIGITS: entry <= {entry[11:0], digit}; count++.
- Otherwise the digit is ignored and entry is unchanged.
- input_screen follows entry in OP1 and OP2.

All register updates land on the clk edge where enter=1 (latency 1).

OP1 state:
- digit: append.
- operator: op1<=entry, op<=code, entry<=0, count<=0, go to OP2.
- CE: entry<=0, count<=0.
- EXE: ignored.

OP2 state:
- digit: append.
- operator with count==0: replace op only (operator change).
- operator with count>0: ignored.
- CE: clear entry.
- EXE: op2<=entry; alu_start=1 for exactly the next cycle; timeout counter <= 0; go to WAIT.

WAIT state:
- Every key except CLR is ignored.
- alu_done=1: input_screen<=alu_result; go to RESULT.
- Counter reaches TIMEOUT without done: err<=1, input_screen<=16'hFFFF, go to RESULT.
- alu_done and timeout in the same cycle: done wins, err stays 0.

RESULT state:
- digit: entry<=digit, count<=1, err<=0, go to OP1.
- operator: op1<=input_screen (chaining), op<=code, entry<=0, count<=0, go to OP2.
- EXE: ignored.
- CE: acts as CLR.

CLR (any state, including WAIT):
- op1, op2, op, entry, count, input_screen and err are set to 0; state <= OP1.
- A stray alu_done after CLR is ignored.
- CLR has priority over alu_done in the same cycle.

General:
- alu_start is never asserted outside the cycle after EXE in OP2.
- Asserting rst mid-WAIT aborts immediately with the reset values.

Test Plan:
1. Hex mode, keys 1,2,+,3,EXE:
   - alu_start pulses once, with op1=0x0012, op2=0x0003, op=0.
   - ALU returns 0x0015 with done -> input_screen=0x0015, state=RESULT.
2. Hex mode, enter digit 7 five times: entry=0x7777 after the 4th press; the 5th press leaves it unchanged. Then decimal mode, key B (pos 3,2) is ignored.
3. In OP2 with count=0, press + then MUL: op=2. In OP2 after a digit, an operator press leaves op unchanged.
4. In WAIT, hold alu_done low for TIMEOUT cycles: err=1, input_screen=0xFFFF, state=RESULT. Then a digit 5 gives err=0, input_screen=0x0005, state=OP1.
5. In RESULT (0x0015), press SUB: op1=0x0015, op=1, state=OP2. CLR pressed in the same cycle as alu_done in WAIT leaves all outputs 0 and state=OP1.
6. Assert rst asynchronously mid-entry and mid-WAIT: outputs are 0 immediately, before the next clk edge; alu_start stays 0.
